// File: rtl/ln_stat_accum.sv
// ln_stat_accum: LayerNorm statistics, mean and population variance over 2**N_LOG2 signed samples.
// Define ROUND_MEAN_EN to round the mean half toward +inf instead of flooring it.
module ln_stat_accum #(
    parameter int DATA_W = 8,
    parameter int N_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  o_ready,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_mean,
    output logic [2*DATA_W-1:0]   o_var,
    output logic                  o_busy
);
    localparam int N  = 1 << N_LOG2;
    localparam int SW = DATA_W + N_LOG2;
    localparam int QW = 2*DATA_W + N_LOG2;
    localparam int PW = 2*DATA_W + 2*N_LOG2;

    typedef enum logic [2:0] {IDLE, ACCUM, MUL, SUB, OUT} state_t;
    state_t state, state_nx;

    logic [N_LOG2-1:0]   count;
    logic [SW-1:0]       sum;
    logic [QW-1:0]       sumsq;
    logic [PW-1:0]       prod;
    logic [SW-1:0]       data_x;
    logic [2*DATA_W-1:0] data_w;
    logic [2*DATA_W-1:0] data_sq;
    logic [PW-1:0]       sum_x;
    logic [PW-1:0]       diff;
    logic [SW-1:0]       sum_r;
    logic                accept;
    logic                last;

    // Sign-extend before multiplying so the truncated unsigned product equals the signed square.
    assign data_x  = {{N_LOG2{i_data[DATA_W-1]}}, i_data};
    assign data_w  = {{DATA_W{i_data[DATA_W-1]}}, i_data};
    assign data_sq = data_w * data_w;
    assign sum_x   = {{(PW-SW){sum[SW-1]}}, sum};
    assign diff    = {sumsq, {N_LOG2{1'b0}}} - prod;
`ifdef ROUND_MEAN_EN
    assign sum_r   = sum + SW'(N/2);
`else
    assign sum_r   = sum;
`endif
    assign accept  = i_valid & o_ready;
    assign last    = (count == N_LOG2'(N-1));

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? ACCUM : IDLE;
            ACCUM:   state_nx = (accept && last) ? MUL : ACCUM;
            MUL:     state_nx = SUB;
            SUB:     state_nx = OUT;
            OUT:     state_nx = i_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_ready = ~i_rst & ((state == IDLE) || (state == ACCUM));
        o_valid = ~i_rst & (state == OUT);
        o_busy  = ~i_rst & (state != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count  <= '0;
            sum    <= '0;
            sumsq  <= '0;
            prod   <= '0;
            o_mean <= '0;
            o_var  <= '0;
        end else begin
            if (accept) begin
                count <= (state == IDLE) ? N_LOG2'(1) : count + N_LOG2'(1);
                sum   <= (state == IDLE) ? data_x : sum + data_x;
                sumsq <= ((state == IDLE) ? '0 : sumsq) + QW'(data_sq);
            end
            if (state == MUL) prod <= sum_x * sum_x;
            if (state == SUB) begin
                o_var  <= (2*DATA_W)'(diff >> (2*N_LOG2));
                o_mean <= DATA_W'(sum_r >> N_LOG2);
            end
        end
    end
endmodule

// File: tb/tb_ln_stat_accum.sv
// tb_ln_stat_accum: directed table-driven bench for ln_stat_accum, plus hold and mid-token reset sequences.
module tb_ln_stat_accum;
    logic        i_clk = 0;
    logic        i_rst = 1;
    logic        i_valid = 0;
    logic        i_ready = 0;
    logic [7:0]  i_data = 0;
    logic        o_ready, o_valid, o_busy;
    logic [7:0]  o_mean;
    logic [15:0] o_var;

    ln_stat_accum #(.DATA_W(8), .N_LOG2(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .i_ready(i_ready), .o_valid(o_valid),
        .o_mean(o_mean), .o_var(o_var), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total = 0;

    typedef struct {
        logic [7:0] d [16];
        int         mean;
        int         vr;
    } vec_t;
    vec_t vecs [5];
    logic [7:0] threes [16];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Streams one token; gap_at inserts a two-cycle i_valid bubble before that sample.
    task automatic feed(input logic [7:0] d [16], input int gap_at);
        for (int k = 0; k < 16; k++) begin
            if (k == gap_at) begin
                i_valid = 0;
                tick;
                tick;
            end
            i_data  = d[k];
            i_valid = 1;
            tick;
        end
        i_valid = 0;
    endtask

    task automatic result(input string tag, input int mean, input int vr, input int hold);
        int lat = 0;
        while (!o_valid && lat < 20) begin
            tick;
            lat++;
        end
        check({tag, " latency"}, lat, 2);
        check({tag, " mean"}, int'($signed(o_mean)), mean);
        check({tag, " var"}, int'(o_var), vr);
        check({tag, " ready in OUT"}, int'(o_ready), 0);
        check({tag, " busy in OUT"}, int'(o_busy), 1);
        for (int h = 0; h < hold; h++) begin
            i_valid = 1;
            i_data  = 8'h63;
            tick;
            check({tag, " hold valid"}, int'(o_valid), 1);
            check({tag, " hold mean"}, int'($signed(o_mean)), mean);
            check({tag, " hold var"}, int'(o_var), vr);
            check({tag, " hold ready"}, int'(o_ready), 0);
        end
        i_valid = 0;
        i_ready = 1;
        tick;
        check({tag, " valid after release"}, int'(o_valid), 0);
        check({tag, " busy after release"}, int'(o_busy), 0);
        check({tag, " ready after release"}, int'(o_ready), 1);
        i_ready = 0;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            vecs[0].d[k] = 8'd5;
            vecs[1].d[k] = (k % 2) ? 8'hF6 : 8'h0A;
            vecs[2].d[k] = 8'(k);
            vecs[3].d[k] = (k % 2) ? 8'h7F : 8'h80;
            vecs[4].d[k] = 8'h80;
            threes[k]    = 8'd3;
        end
        vecs[0].mean = 5;    vecs[0].vr = 0;
        vecs[1].mean = 0;    vecs[1].vr = 100;
        vecs[2].vr   = 21;
        vecs[3].vr   = 16256;
        vecs[4].mean = -128; vecs[4].vr = 0;
`ifdef ROUND_MEAN_EN
        vecs[2].mean = 8;
        vecs[3].mean = 0;
`else
        vecs[2].mean = 7;
        vecs[3].mean = -1;
`endif

        tick;
        check("reset valid", int'(o_valid), 0);
        check("reset mean", int'(o_mean), 0);
        check("reset var", int'(o_var), 0);
        check("reset busy", int'(o_busy), 0);
        check("reset ready", int'(o_ready), 0);
        i_rst = 0;
        #1;
        check("idle ready", int'(o_ready), 1);

        for (int v = 0; v < 5; v++) begin
            feed(vecs[v].d, -1);
            result($sformatf("vec%0d", v), vecs[v].mean, vecs[v].vr, 0);
        end

        feed(vecs[3].d, -1);
        result("hold5", vecs[3].mean, vecs[3].vr, 5);

        for (int k = 0; k < 7; k++) begin
            i_data  = 8'h7F;
            i_valid = 1;
            tick;
        end
        i_valid = 0;
        check("mid-token busy", int'(o_busy), 1);
        i_rst = 1;
        tick;
        i_rst = 0;
        #1;
        check("post-reset busy", int'(o_busy), 0);
        check("post-reset valid", int'(o_valid), 0);
        feed(threes, 5);
        result("fresh3", 3, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
